// File: rtl/lightpipe_pkg.sv
// Shared lightpipe frame geometry and receiver state encoding.
// Also used by the transmitter, so keep the frame layout here only.
package lightpipe_pkg;

  localparam int FRAME_BITS = 256;
  localparam int SYNC_ZEROS = 10;
  localparam int NUM_CH     = 8;
  localparam int CH_W       = 24;
  localparam int USR_W      = 4;
  localparam int NIB_PER_CH = 6;

  // Payload kept by the receiver: user bits followed by ch1..ch8, separators dropped.
  localparam int STAGE_W   = USR_W + NUM_CH * CH_W;
  localparam int USR_FIRST = SYNC_ZEROS + 1;
  localparam int GRP_FIRST = USR_FIRST + USR_W;
  localparam int GRP_LAST  = GRP_FIRST + 5 * (NUM_CH * NIB_PER_CH - 1);

  typedef enum logic [1:0] {HUNT, DATA, SYNC} lp_state_t;

  function automatic logic is_separator(input logic [7:0] bit_idx);
    int b;
    b = int'(bit_idx);
    return (b >= GRP_FIRST) && (b <= GRP_LAST) && (((b - GRP_FIRST) % 5) == 0);
  endfunction

endpackage

// File: rtl/lp_nrzi_sampler.sv
// Oversampling NRZI bit recovery: synchroniser, edge detect, phase counter
// re-centred on every line transition, and a no-edge watchdog.
module lp_nrzi_sampler #(
  parameter int BIT_PERIOD = 20,
  parameter int SYNC_MIN   = 8
) (
  input  logic hclk,
  input  logic rst,
  input  logic lightpipe,
  output logic bit_vld,
  output logic bit_val,
  output logic edge_timeout
);

  localparam int TIMEOUT = 2 * BIT_PERIOD * SYNC_MIN;
  localparam int PH_W    = $clog2(BIT_PERIOD);
  localparam int IDLE_W  = $clog2(TIMEOUT + 2);
  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(BIT_PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_MID     = PH_W'(BIT_PERIOD / 2);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);

  logic [1:0]        sync_reg;
  logic              prev_reg;
  logic [PH_W-1:0]   phase_reg;
  logic              trans_reg;
  logic [IDLE_W-1:0] idle_reg;
  logic              line_edge;
  logic              sample;

  assign line_edge = sync_reg[1] ^ prev_reg;
  // An edge landing on the sample point re-centres the phase and suppresses that sample.
  assign sample    = !line_edge && (phase_reg == PH_MID);

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      sync_reg     <= '0;
      prev_reg     <= 1'b0;
      phase_reg    <= '0;
      trans_reg    <= 1'b0;
      idle_reg     <= '0;
      bit_vld      <= 1'b0;
      bit_val      <= 1'b0;
      edge_timeout <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], lightpipe};
      prev_reg <= sync_reg[1];

      if (line_edge || phase_reg == PH_LAST) phase_reg <= '0;
      else                                   phase_reg <= phase_reg + 1'b1;

      if (line_edge)   trans_reg <= 1'b1;
      else if (sample) trans_reg <= 1'b0;

      bit_vld <= sample;
      bit_val <= trans_reg;

      // Saturates one past the limit so the timeout fires once per silent stretch.
      edge_timeout <= 1'b0;
      if (line_edge) begin
        idle_reg <= '0;
      end else if (idle_reg <= IDLE_LIMIT) begin
        idle_reg     <= idle_reg + 1'b1;
        edge_timeout <= (idle_reg == IDLE_LIMIT);
      end
    end
  end

endmodule

// File: rtl/lightpipe_deframer.sv
// Lightpipe receiver: frame sync FSM, payload staging and held channel outputs
// on top of the NRZI bit recovery.
module lightpipe_deframer
  import lightpipe_pkg::*;
#(
  parameter int BIT_PERIOD  = 20,
  parameter int SYNC_MIN    = 8,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              hclk,
  input  logic              rst,
  input  logic              lightpipe,
  output logic [CH_W-1:0]   ch1,
  output logic [CH_W-1:0]   ch2,
  output logic [CH_W-1:0]   ch3,
  output logic [CH_W-1:0]   ch4,
  output logic [CH_W-1:0]   ch5,
  output logic [CH_W-1:0]   ch6,
  output logic [CH_W-1:0]   ch7,
  output logic [CH_W-1:0]   ch8,
  output logic [USR_W-1:0]  rx_usr,
  output logic              frame_stb,
  output logic              locked,
  output logic              frame_err
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_FRAMES);
  localparam logic [3:0]        RUN_MIN   = 4'(SYNC_MIN);
  localparam logic [3:0]        RUN_SYNC  = 4'(SYNC_ZEROS);
  localparam logic [7:0]        LAST_BIT  = 8'(FRAME_BITS - 1);
  localparam logic [7:0]        FIRST_BIT = 8'(USR_FIRST);

  logic bit_vld, bit_val, edge_timeout;

  lp_nrzi_sampler #(
    .BIT_PERIOD (BIT_PERIOD),
    .SYNC_MIN   (SYNC_MIN)
  ) u_sampler (
    .hclk         (hclk),
    .rst          (rst),
    .lightpipe    (lightpipe),
    .bit_vld      (bit_vld),
    .bit_val      (bit_val),
    .edge_timeout (edge_timeout)
  );

  lp_state_t          state_reg, state_next;
  logic [7:0]         bit_cnt_reg, bit_cnt_next;
  logic [3:0]         zero_run_reg, zero_run_next;
  logic [GOOD_W-1:0]  good_cnt_reg, good_cnt_next;
  logic [STAGE_W-1:0] stage_reg, stage_next;
  logic [STAGE_W-1:0] frame_reg;
  logic               locked_next, load, err_next;

  assign {rx_usr, ch1, ch2, ch3, ch4, ch5, ch6, ch7, ch8} = frame_reg;

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    zero_run_next = zero_run_reg;
    good_cnt_next = good_cnt_reg;
    stage_next    = stage_reg;
    locked_next   = locked;
    load          = 1'b0;
    err_next      = 1'b0;

    if (edge_timeout) begin
      state_next    = HUNT;
      good_cnt_next = '0;
      locked_next   = 1'b0;
    end else if (bit_vld) begin
      if (bit_val)                  zero_run_next = '0;
      else if (zero_run_reg != 4'hF) zero_run_next = zero_run_reg + 4'd1;

      case (state_reg)
        HUNT: begin
          if (bit_val && zero_run_reg >= RUN_MIN) begin
            state_next   = DATA;
            bit_cnt_next = FIRST_BIT;
          end
        end
        SYNC: begin
          // A gap shortened to SYNC_MIN by transmitter clock drift still counts as sync.
          if (bit_val) begin
            if (zero_run_reg >= RUN_MIN) begin
              state_next   = DATA;
              bit_cnt_next = FIRST_BIT;
            end else begin
              state_next    = HUNT;
              err_next      = 1'b1;
              locked_next   = 1'b0;
              good_cnt_next = '0;
            end
          end else if (zero_run_reg == RUN_SYNC) begin
            state_next = HUNT;
          end
        end
        DATA: begin
          if (bit_cnt_reg == LAST_BIT || is_separator(bit_cnt_reg)) begin
            if (!bit_val) begin
              state_next    = HUNT;
              err_next      = 1'b1;
              locked_next   = 1'b0;
              good_cnt_next = '0;
            end else if (bit_cnt_reg == LAST_BIT) begin
              state_next = SYNC;
              load       = 1'b1;
              if (good_cnt_reg != GOOD_MAX)            good_cnt_next = good_cnt_reg + 1'b1;
              if (good_cnt_reg >= GOOD_MAX - 1'b1)     locked_next   = 1'b1;
            end else begin
              bit_cnt_next = bit_cnt_reg + 8'd1;
            end
          end else begin
            stage_next   = {stage_reg[STAGE_W-2:0], bit_val};
            bit_cnt_next = bit_cnt_reg + 8'd1;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      state_reg    <= HUNT;
      bit_cnt_reg  <= '0;
      zero_run_reg <= '0;
      good_cnt_reg <= '0;
      stage_reg    <= '0;
      frame_reg    <= '0;
      frame_stb    <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      zero_run_reg <= zero_run_next;
      good_cnt_reg <= good_cnt_next;
      stage_reg    <= stage_next;
      frame_stb    <= load;
      frame_err    <= err_next;
      locked       <= locked_next;
      if (load) frame_reg <= stage_reg;
    end
  end

endmodule

// File: tb/tb_lightpipe_deframer.sv
// Scoreboard bench for lightpipe_deframer: a transmitter model queues the expected
// payload of each frame it sends, a monitor pops and compares on every frame_stb.
module tb_lightpipe_deframer;

  logic        hclk = 1'b0;
  logic        rst;
  logic        lightpipe;
  logic [23:0] ch1, ch2, ch3, ch4, ch5, ch6, ch7, ch8;
  logic [3:0]  rx_usr;
  logic        frame_stb, locked, frame_err;

  int total = 0;
  int bad = 0;
  int err_seen = 0;

  logic [195:0] exp_q[$];
  logic [195:0] mon_exp, mon_got;

  lightpipe_deframer dut (
    .hclk      (hclk),
    .rst       (rst),
    .lightpipe (lightpipe),
    .ch1       (ch1),
    .ch2       (ch2),
    .ch3       (ch3),
    .ch4       (ch4),
    .ch5       (ch5),
    .ch6       (ch6),
    .ch7       (ch7),
    .ch8       (ch8),
    .rx_usr    (rx_usr),
    .frame_stb (frame_stb),
    .locked    (locked),
    .frame_err (frame_err)
  );

  always #2 hclk = ~hclk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  always @(negedge hclk) begin
    if (frame_err === 1'b1) err_seen++;
    if (frame_stb === 1'b1) begin
      total++;
      mon_got = {rx_usr, ch1, ch2, ch3, ch4, ch5, ch6, ch7, ch8};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL frame_stb_unexpected: got %h, required no strobe", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL frame_data: got %h, required %h", mon_got, mon_exp);
        end else begin
          $display("frame ok: usr=%h ch1=%h ch2=%h ch8=%h", rx_usr, ch1, ch2, ch8);
        end
      end
    end
  end

  function automatic logic [255:0] build_frame(input logic [191:0] chs, input logic [3:0] usr);
    logic [255:0] f;
    logic [3:0]   nib;
    f = '0;
    f[10] = 1'b1;
    for (int j = 0; j < 4; j++) f[11 + j] = usr[3 - j];
    for (int k = 0; k < 48; k++) begin
      nib = chs[191 - 4 * k -: 4];
      f[15 + 5 * k] = 1'b1;
      for (int j = 0; j < 4; j++) f[16 + 5 * k + j] = nib[3 - j];
    end
    f[255] = 1'b1;
    return f;
  endfunction

  function automatic logic [191:0] count_pattern(input logic [191:0] base, input int n);
    logic [191:0] r;
    logic [23:0]  v;
    for (int i = 0; i < 8; i++) begin
      v = base[191 - 24 * i -: 24];
      if (i % 2 == 0) v = v - 24'(n);
      else            v = v + 24'(n);
      r[191 - 24 * i -: 24] = v;
    end
    return r;
  endfunction

  task automatic check_val(input string name, input int got, input int req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end else begin
      $display("check %s ok: %0d", name, got);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    logic [199:0] snap;
    snap = {rx_usr, ch1, ch2, ch3, ch4, ch5, ch6, ch7, ch8, frame_stb, locked, frame_err, 1'b0};
    total++;
    if (snap !== '0) begin
      bad++;
      $display("FAIL %s: got outputs %h, required all zero", name, snap);
    end else begin
      $display("check %s ok: outputs zero", name);
    end
  endtask

  task automatic send_frame(input logic [191:0] chs, input logic [3:0] usr, input int period,
                            input int flip_bit, input int rst_bit, input bit expect_ok);
    logic [255:0] f;
    f = build_frame(chs, usr);
    if (flip_bit >= 0) f[flip_bit] = ~f[flip_bit];
    if (expect_ok) exp_q.push_back({usr, chs});
    for (int b = 0; b < 256; b++) begin
      @(negedge hclk);
      if (f[b]) lightpipe = ~lightpipe;
      for (int c = 1; c < period; c++) begin
        if (b == rst_bit && c == 1) begin
          rst = 1'b1;
          #1 check_zero_outputs("mid_frame_reset");
        end
        if (b == rst_bit && c == 4) rst = 1'b0;
        @(negedge hclk);
      end
    end
  endtask

  logic [191:0] base, nz1, nz2, cnt4, cnt7;

  initial begin
    base = {24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000,
            24'h000000, 24'h000000, 24'h000000, 24'h000000};
    nz1  = {24'h123456, 24'h789ABC, 24'hDEF123, 24'h456789,
            24'hABCDEF, 24'h1A2B3C, 24'h4D5E6F, 24'h7F8E9D};
    nz2  = {24'h654321, 24'hCBA987, 24'h321FED, 24'h987654,
            24'hFEDCBA, 24'hC3B2A1, 24'hF6E5D4, 24'hD9E8F7};
    cnt4 = count_pattern(base, 4);
    cnt7 = count_pattern(base, 7);

    rst = 1'b1;
    lightpipe = 1'b0;
    repeat (5) @(negedge hclk);
    check_zero_outputs("reset_state");
    rst = 1'b0;
    repeat (50) @(negedge hclk);

    // Reference pattern: lock after two frames.
    send_frame(base, 4'h3, 20, -1, -1, 1'b1);
    check_val("locked_after_frame1", int'(locked), 0);
    send_frame(base, 4'h3, 20, -1, -1, 1'b1);
    check_val("locked_after_frame2", int'(locked), 1);

    // Counting pattern.
    for (int n = 1; n <= 4; n++)
      send_frame(count_pattern(base, n), 4'(n), 20, -1, -1, 1'b1);
    check_val("no_err_counting", err_seen, 0);
    check_val("locked_counting", int'(locked), 1);

    // Group 17 separator flipped: rejected, outputs keep the previous frame.
    send_frame(nz1, 4'hA, 20, 15 + 5 * 17, -1, 1'b0);
    check_val("err_on_bad_separator", err_seen, 1);
    check_val("locked_after_bad", int'(locked), 0);
    total++;
    if ({rx_usr, ch1, ch2, ch3, ch4, ch5, ch6, ch7, ch8} !== {4'h4, cnt4}) begin
      bad++;
      $display("FAIL hold_after_bad: got %h, required %h",
               {rx_usr, ch1, ch2, ch3, ch4, ch5, ch6, ch7, ch8}, {4'h4, cnt4});
    end else begin
      $display("check hold_after_bad ok");
    end
    send_frame(nz2, 4'h5, 20, -1, -1, 1'b1);
    check_val("locked_relock1", int'(locked), 0);
    send_frame(nz1, 4'hB, 20, -1, -1, 1'b1);
    check_val("locked_relock2", int'(locked), 1);

    // Static line: timeout unlocks without an error; relock at -5% then +5% bit period.
    repeat (1250) @(negedge hclk);
    check_val("locked_after_timeout", int'(locked), 0);
    check_val("no_err_timeout", err_seen, 1);
    send_frame(nz1, 4'hC, 19, -1, -1, 1'b1);
    check_val("locked_after_p19", int'(locked), 0);
    send_frame(cnt7, 4'h6, 21, -1, -1, 1'b1);
    check_val("locked_after_p21", int'(locked), 1);

    // Reset at bit 120, then the following frame must decode.
    send_frame(nz1, 4'h9, 20, -1, 120, 1'b0);
    send_frame(nz2, 4'h2, 20, -1, -1, 1'b1);
    check_val("locked_after_reset_frame", int'(locked), 0);

    repeat (20) @(negedge hclk);
    check_val("all_frames_strobed", exp_q.size(), 0);
    check_val("final_err_count", err_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
